// File: rtl/vx_dp_ram_arbiter_pkg.sv
// Shared types and width helpers for the dual-port RAM arbiter.
package vx_ram_arb_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   // Address/index width that never collapses to zero bits.
   function automatic int log2up(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a round-robin pointer for n requesters.
   function automatic int rr_ptrw(input int n);
      return log2up(n);
   endfunction

endpackage

// File: rtl/vx_dp_ram_arbiter_rr_grant.sv
// Round-robin grant: priority starts one past the last accepted requester.
module vx_rr_grant
   import vx_ram_arb_pkg::*;
#(
   parameter int NUM_REQS = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQS-1:0]            valid,
   input  logic                           enable,
   output logic [NUM_REQS-1:0]            grant,
   output logic [rr_ptrw(NUM_REQS)-1:0]   grant_idx
);

   localparam int PTRW = rr_ptrw(NUM_REQS);

   logic [PTRW-1:0] last_q;
   logic [PTRW-1:0] cidx;
   logic            found;
   int              cand;

   // Scan requesters starting at last_q+1 and pick the first valid one.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      cidx      = '0;
      for (int k = 1; k <= NUM_REQS; k++) begin
         cand = (int'(last_q) + k) % NUM_REQS;
         cidx = PTRW'(cand);
         if (enable && !found && valid[cidx]) begin
            found       = 1'b1;
            grant[cidx] = 1'b1;
            grant_idx   = cidx;
         end
      end
   end

   // Remember the winner; reset value makes requester 0 highest priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= PTRW'(NUM_REQS - 1);
      end else if (|grant) begin
         last_q <= grant_idx;
      end
   end

endmodule

// File: rtl/vx_dp_ram_arbiter.sv
// Shares one 1W/1R registered-read RAM among NUM_REQS requesters, with a
// clear sweep that initialises every entry after reset or on request.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   CLEAR | sweeping INIT_VALUE into entry ptr each cycle; no grants
//   READY | normal operation; independent write and read round-robin
module vx_dp_ram_arbiter
   import vx_ram_arb_pkg::*;
#(
   parameter int                NUM_REQS   = 4,
   parameter int                DATAW      = 32,
   parameter int                SIZE       = 64,
   parameter int                WRENW      = 1,
   parameter logic [DATAW-1:0]  INIT_VALUE = '0,
   parameter int                ADDRW      = log2up(SIZE)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   output logic                       busy,
   input  logic [NUM_REQS-1:0]        wr_valid,
   input  logic [NUM_REQS*ADDRW-1:0]  wr_addr,
   input  logic [NUM_REQS*WRENW-1:0]  wr_wren,
   input  logic [NUM_REQS*DATAW-1:0]  wr_data,
   output logic [NUM_REQS-1:0]        wr_ready,
   input  logic [NUM_REQS-1:0]        rd_valid,
   input  logic [NUM_REQS*ADDRW-1:0]  rd_addr,
   output logic [NUM_REQS-1:0]        rd_ready,
   output logic [NUM_REQS-1:0]        rsp_valid,
   output logic [DATAW-1:0]           rsp_data
);

   localparam int RR_PTRW = rr_ptrw(NUM_REQS);
   localparam int LANEW   = DATAW / WRENW;

   state_t              state_q, state_d;
   logic [ADDRW-1:0]    ptr_q, ptr_d;
   logic                arb_en;
   logic [RR_PTRW-1:0]  wr_idx, rd_idx;
   logic [NUM_REQS-1:0] wr_grant, rd_grant;

   logic                ram_we;
   logic [ADDRW-1:0]    ram_waddr, ram_raddr;
   logic [WRENW-1:0]    ram_wren;
   logic [DATAW-1:0]    ram_wdata;
   logic [DATAW-1:0]    mem [SIZE];

   // State and sweep pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next state: sweep to the last entry, a clear pulse always restarts at 0.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         CLEAR: begin
            if (clear) begin
               ptr_d = '0;
            end else if (ptr_q == ADDRW'(SIZE - 1)) begin
               state_d = READY;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         READY: begin
            if (clear) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   assign busy   = (state_q == CLEAR);
   assign arb_en = (state_q == READY);

   vx_rr_grant #(.NUM_REQS(NUM_REQS)) u_wr_arb (
      .clk       (clk),
      .reset     (reset),
      .valid     (wr_valid),
      .enable    (arb_en),
      .grant     (wr_grant),
      .grant_idx (wr_idx)
   );

   vx_rr_grant #(.NUM_REQS(NUM_REQS)) u_rd_arb (
      .clk       (clk),
      .reset     (reset),
      .valid     (rd_valid),
      .enable    (arb_en),
      .grant     (rd_grant),
      .grant_idx (rd_idx)
   );

   assign wr_ready  = wr_grant;
   assign rd_ready  = rd_grant;
   assign ram_raddr = rd_addr[rd_idx*ADDRW +: ADDRW];

   // Write port source: the sweep owns it in CLEAR, the write winner in READY.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = ptr_q;
      ram_wren  = '1;
      ram_wdata = INIT_VALUE;
      if (state_q == CLEAR) begin
         ram_we = 1'b1;
      end else if (|wr_grant) begin
         ram_we    = 1'b1;
         ram_waddr = wr_addr[wr_idx*ADDRW +: ADDRW];
         ram_wren  = wr_wren[wr_idx*WRENW +: WRENW];
         ram_wdata = wr_data[wr_idx*DATAW +: DATAW];
      end
   end

   // RAM storage with per-lane write enables; never reset, the sweep initialises it.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int l = 0; l < WRENW; l++) begin
            if (ram_wren[l]) begin
               mem[ram_waddr][l*LANEW +: LANEW] <= ram_wdata[l*LANEW +: LANEW];
            end
         end
      end
   end

   // Registered read: same-cycle write is not forwarded, so the old data returns.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= rd_grant;
         if (|rd_grant) begin
            rsp_data <= mem[ram_raddr];
         end
      end
   end

endmodule

// File: tb/tb_vx_dp_ram_arbiter.sv
// Randomised and directed bench with a queue-based response scoreboard.
module tb_vx_dp_ram_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int SZ = 64;
   localparam int WE = 4;
   localparam int AW = 6;
   localparam int LW = DW / WE;

   logic              clk = 1'b0;
   logic              reset, clear, busy;
   logic [N-1:0]      wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid;
   logic [N*AW-1:0]   wr_addr, rd_addr;
   logic [N*WE-1:0]   wr_wren;
   logic [N*DW-1:0]   wr_data;
   logic [DW-1:0]     rsp_data;

   vx_dp_ram_arbiter #(
      .NUM_REQS(N), .DATAW(DW), .SIZE(SZ), .WRENW(WE), .INIT_VALUE('0)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear), .busy(busy),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_wren(wr_wren), .wr_data(wr_data),
      .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      int          req;
      logic [DW-1:0] data;
   } exp_t;

   // Requester-side pending requests (held until accepted)
   bit            wp [N];
   logic [AW-1:0] wa [N];
   logic [WE-1:0] ww [N];
   logic [DW-1:0] wd [N];
   bit            rp [N];
   logic [AW-1:0] ra [N];

   // Reference model
   logic [DW-1:0] mm [SZ];
   int            lw, lr, busy_left;
   exp_t          exp_q[$];

   int  tests = 0;
   int  fails = 0;
   int  ecnt  = 0;
   bit  mon_en = 1'b0;
   exp_t mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) ecnt++;

   // Monitor: every edge either delivers the oldest expected response or nothing.
   always @(posedge clk) begin
      #2;
      if (mon_en) begin
         if (exp_q.size() > 0 && exp_q[0].due == ecnt) begin
            mon_e = exp_q.pop_front();
            check("rsp_valid", 64'(rsp_valid), 64'(1) << mon_e.req);
            check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
         end else begin
            check("rsp_idle", 64'(rsp_valid), 64'd0);
         end
      end
   end

   function automatic void model_clear_mem();
      for (int a = 0; a < SZ; a++) mm[a] = '0;
   endfunction

   // One clock cycle: drive pending requests, then predict and check this cycle.
   task automatic step(input bit do_clear, input bit do_reset);
      int gw, gr, c;
      logic [N-1:0] ew, er;
      @(posedge clk);
      #1;
      reset = do_reset;
      clear = do_clear;
      for (int i = 0; i < N; i++) begin
         wr_valid[i]            = wp[i];
         wr_addr[i*AW +: AW]    = wa[i];
         wr_wren[i*WE +: WE]    = ww[i];
         wr_data[i*DW +: DW]    = wd[i];
         rd_valid[i]            = rp[i];
         rd_addr[i*AW +: AW]    = ra[i];
      end
      @(negedge clk);
      if (do_reset) begin
         lw = N - 1;
         lr = N - 1;
         busy_left = SZ;
         model_clear_mem();
      end else begin
         check("busy", 64'(busy), 64'(busy_left > 0));
         gw = -1;
         gr = -1;
         if (busy_left == 0) begin
            for (int k = 1; k <= N; k++) begin
               c = (lw + k) % N;
               if (gw < 0 && wp[c]) gw = c;
               c = (lr + k) % N;
               if (gr < 0 && rp[c]) gr = c;
            end
         end
         ew = '0;
         er = '0;
         if (gw >= 0) ew[gw] = 1'b1;
         if (gr >= 0) er[gr] = 1'b1;
         check("wr_ready", 64'(wr_ready), 64'(ew));
         check("rd_ready", 64'(rd_ready), 64'(er));
         if (gr >= 0) begin
            exp_q.push_back('{due: ecnt + 1, req: gr, data: mm[ra[gr]]});
            rp[gr] = 1'b0;
            lr = gr;
         end
         if (gw >= 0) begin
            for (int l = 0; l < WE; l++)
               if (ww[gw][l]) mm[wa[gw]][l*LW +: LW] = wd[gw][l*LW +: LW];
            wp[gw] = 1'b0;
            lw = gw;
         end
         if (do_clear) begin
            busy_left = SZ;
            model_clear_mem();
         end else if (busy_left > 0) begin
            busy_left--;
         end
      end
   endtask

   task automatic set_wr(input int i, input int a, input logic [WE-1:0] en, input logic [DW-1:0] d);
      wp[i] = 1'b1; wa[i] = AW'(a); ww[i] = en; wd[i] = d;
   endtask

   task automatic set_rd(input int i, input int a);
      rp[i] = 1'b1; ra[i] = AW'(a);
   endtask

   // Read every entry, spreading the addresses over free requesters.
   task automatic read_all();
      int nxt, busy_pend;
      nxt = 0;
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++)
            if (!rp[i] && nxt < SZ) begin set_rd(i, nxt); nxt++; end
         step(1'b0, 1'b0);
         busy_pend = 0;
         for (int i = 0; i < N; i++) if (rp[i]) busy_pend = 1;
         if (nxt == SZ && busy_pend == 0) break;
      end
      check("read_all_done", 64'(nxt), 64'(SZ));
   endtask

   // Run until the sweep finishes, returning how many busy cycles were seen.
   task automatic wait_sweep(output int nb);
      nb = 0;
      for (int k = 0; k < 200; k++) begin
         step(1'b0, 1'b0);
         if (busy === 1'b1) nb++;
         else if (nb > 0 || k > 0) break;
      end
   endtask

   int nb;

   initial begin
      reset = 1'b1; clear = 1'b0;
      wr_valid = '0; rd_valid = '0; wr_addr = '0; rd_addr = '0; wr_wren = '0; wr_data = '0;
      for (int i = 0; i < N; i++) begin
         wp[i] = 0; rp[i] = 0; wa[i] = '0; ww[i] = '0; wd[i] = '0; ra[i] = '0;
      end
      lw = N - 1; lr = N - 1; busy_left = SZ;
      model_clear_mem();

      step(1'b0, 1'b1);
      mon_en = 1'b1;
      step(1'b0, 1'b1);
      check("rst_busy", 64'(busy), 64'd1);
      check("rst_wr_ready", 64'(wr_ready), 64'd0);
      check("rst_rd_ready", 64'(rd_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);

      // Initial sweep length, then every entry reads back as the init value.
      wait_sweep(nb);
      check("sweep_len", 64'(nb), 64'(SZ));
      read_all();
      repeat (2) step(1'b0, 1'b0);

      // All writers held valid: round-robin rotation, reloaded on acceptance.
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < N; i++)
            if (!wp[i]) set_wr(i, 20 + $urandom_range(0, 3), 4'hF, $urandom);
         step(1'b0, 1'b0);
      end
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
      for (int a = 20; a < 24; a++) begin set_rd(a - 20, a); end
      repeat (3) step(1'b0, 1'b0);

      // Same-cycle write and read of one address: old data, then new data.
      set_wr(0, 5, 4'hF, 32'hAAAA_5555);
      set_rd(1, 5);
      step(1'b0, 1'b0);
      set_rd(2, 5);
      step(1'b0, 1'b0);

      // Partial lane write.
      set_wr(3, 7, 4'hF, 32'h1122_3344);
      step(1'b0, 1'b0);
      set_wr(1, 7, 4'b0101, 32'hFFFF_FFFF);
      step(1'b0, 1'b0);
      set_rd(0, 7);
      repeat (2) step(1'b0, 1'b0);
      // Empty lane mask still consumed, contents unchanged.
      set_wr(2, 7, 4'b0000, 32'h0BAD_0BAD);
      step(1'b0, 1'b0);
      set_rd(3, 7);
      repeat (2) step(1'b0, 1'b0);

      // Clear pulse, restarted on the 10th busy cycle.
      step(1'b1, 1'b0);
      nb = 0;
      for (int k = 1; k < 200; k++) begin
         step(k == 10, 1'b0);
         if (busy === 1'b1) nb++;
         else break;
      end
      check("restart_len", 64'(nb), 64'(10 + SZ));
      read_all();
      repeat (2) step(1'b0, 1'b0);

      // Read accepted in the same cycle as a clear returns pre-clear data.
      set_wr(0, 3, 4'hF, 32'hDEAD_BEEF);
      step(1'b0, 1'b0);
      set_rd(1, 3);
      step(1'b1, 1'b0);
      wait_sweep(nb);
      check("clear_len", 64'(nb), 64'(SZ));

      // Read in T, reset in T+1 with another read pending: no response in T+2.
      set_wr(2, 9, 4'hF, 32'h1234_5678);
      step(1'b0, 1'b0);
      set_rd(0, 9);
      step(1'b0, 1'b0);
      set_rd(1, 9);
      step(1'b0, 1'b1);
      wait_sweep(nb);
      check("reset_sweep_len", 64'(nb), 64'(SZ));

      // Random traffic over a small address window with occasional clears.
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!wp[i] && $urandom_range(0, 2) == 0)
               set_wr(i, $urandom_range(0, 7), WE'($urandom), $urandom);
            if (!rp[i] && $urandom_range(0, 2) == 0)
               set_rd(i, $urandom_range(0, 7));
         end
         step($urandom_range(0, 249) == 0, 1'b0);
      end
      for (int k = 0; k < 80; k++) step(1'b0, 1'b0);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
